issue_sb: RTL and testbench

Parametrised, scoreboarded issue stage between decode/register-file read and the execution units (ALU, PC-ALU, LSU). It generalises the single-cycle operand-selection issue to configurable data and register-file widths. It adds a per-register busy scoreboard with RAW/WAW stall, write-back forwarding, a valid/ready output register with back-pressure, flush, and a saturating hazard-stall counter.

---
 rtl/issue_sb_if.sv | 78 +++++++
 rtl/issue_sb.sv | 158 +++++++++++++++
 tb/tb_issue_sb.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_sb_if.sv
// Shared ALU operator encoding plus the decode-side and issue-side buses of issue_sb.
// Each bus uses a master/slave modport pair. The master is the side that drives valid.
package issue_sb_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;
endpackage

interface issue_sb_dec_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  import issue_sb_pkg::*;
  logic            dec_valid;
  logic            dec_ready;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [AW-1:0]   rd_addr;
  logic            rs1_used;
  logic            rs2_used;
  logic            rd_we;
  logic [1:0]      op_a_sel;
  logic            op_b_sel;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc;
  logic [1:0]      unit;
  alu_op_e         alu_op;
  logic            lsu_we;

  modport master (
    output dec_valid, rs1_addr, rs2_addr, rd_addr, rs1_used, rs2_used, rd_we,
           op_a_sel, op_b_sel, imm, pc, unit, alu_op, lsu_we,
    input  dec_ready
  );
  modport slave (
    input  dec_valid, rs1_addr, rs2_addr, rd_addr, rs1_used, rs2_used, rd_we,
           op_a_sel, op_b_sel, imm, pc, unit, alu_op, lsu_we,
    output dec_ready
  );
endinterface

interface issue_sb_iss_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  import issue_sb_pkg::*;
  logic            iss_valid;
  logic            iss_ready;
  logic [1:0]      iss_unit;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic [XLEN-1:0] lsu_wdata;
  logic [XLEN-1:0] pc;
  logic [AW-1:0]   rd_addr;
  logic            rd_we;
  logic            lsu_we;
  alu_op_e         alu_op;

  modport master (
    output iss_valid, iss_unit, operand_a, operand_b, lsu_wdata, pc, rd_addr,
           rd_we, lsu_we, alu_op,
    input  iss_ready
  );
  modport slave (
    input  iss_valid, iss_unit, operand_a, operand_b, lsu_wdata, pc, rd_addr,
           rd_we, lsu_we, alu_op,
    output iss_ready
  );
endinterface

// File: rtl/issue_sb.sv
// Scoreboarded issue stage: RAW/WAW stall, write-back forwarding, one-entry output register.
// 1-cycle accept-to-valid latency; the payload holds while iss_ready is low; flush empties the stage.
module issue_sb
  import issue_sb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int SCNT_W = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  issue_sb_dec_if.slave       dec_bus,
  issue_sb_iss_if.master      iss_bus,
  input  logic [XLEN-1:0]     rf_rdata_a_i,
  input  logic [XLEN-1:0]     rf_rdata_b_i,
  input  logic                wb_valid_i,
  input  logic [AW-1:0]       wb_addr_i,
  input  logic [XLEN-1:0]     wb_data_i,
  input  logic                flush_i,
  output logic [SCNT_W-1:0]   stall_cnt_o
);

  localparam logic [1:0] UNIT_ALU = 2'd0;
  localparam logic [1:0] UNIT_LSU = 2'd2;

  typedef enum logic {S_EMPTY, S_FULL} state_e;

  state_e            state_q, state_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;

  logic [1:0]        unit_q, unit_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic              rd_we_q, rd_we_d;
  logic              lsu_we_q, lsu_we_d;
  alu_op_e           alu_op_q, alu_op_d;

  logic              wb_hit1, wb_hit2, wb_hitd;
  logic [XLEN-1:0]   fwd1, fwd2;
  logic              haz, free, accept, iss_valid, is_lsu;

  always_comb begin
    wb_hit1 = wb_valid_i && (wb_addr_i == dec_bus.rs1_addr);
    wb_hit2 = wb_valid_i && (wb_addr_i == dec_bus.rs2_addr);
    wb_hitd = wb_valid_i && (wb_addr_i == dec_bus.rd_addr);
    fwd1 = (dec_bus.rs1_addr == '0) ? '0 : (wb_hit1 ? wb_data_i : rf_rdata_a_i);
    fwd2 = (dec_bus.rs2_addr == '0) ? '0 : (wb_hit2 ? wb_data_i : rf_rdata_b_i);
    // A write-back landing this cycle releases the register immediately.
    haz = (dec_bus.rs1_used && (dec_bus.rs1_addr != '0) && busy_q[dec_bus.rs1_addr] && !wb_hit1)
       || (dec_bus.rs2_used && (dec_bus.rs2_addr != '0) && busy_q[dec_bus.rs2_addr] && !wb_hit2)
       || (dec_bus.rd_we    && (dec_bus.rd_addr  != '0) && busy_q[dec_bus.rd_addr]  && !wb_hitd);
  end

  assign iss_valid        = (state_q == S_FULL);
  assign free             = !iss_valid || iss_bus.iss_ready;
  assign dec_bus.dec_ready = rst_ni && free && !haz && !flush_i;
  assign accept           = dec_bus.dec_valid && dec_bus.dec_ready;
  assign is_lsu           = (dec_bus.unit == UNIT_LSU);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: if (accept) state_d = S_FULL;
      S_FULL:  if (iss_bus.iss_ready && !accept) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
    if (flush_i) state_d = S_EMPTY;
  end

  always_comb begin
    unit_d   = unit_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    wdata_d  = wdata_q;
    pc_d     = pc_q;
    rd_d     = rd_q;
    rd_we_d  = rd_we_q;
    lsu_we_d = lsu_we_q;
    alu_op_d = alu_op_q;
    if (accept) begin
      unit_d = (dec_bus.unit == 2'd3) ? UNIT_ALU : dec_bus.unit;
      unique case (dec_bus.op_a_sel)
        2'd0:    opa_d = fwd1;
        2'd2:    opa_d = dec_bus.pc;
        default: opa_d = '0;
      endcase
      opb_d    = dec_bus.op_b_sel ? dec_bus.imm : fwd2;
      wdata_d  = (is_lsu && dec_bus.lsu_we) ? fwd2 : '0;
      pc_d     = dec_bus.pc;
      rd_d     = dec_bus.rd_addr;
      rd_we_d  = dec_bus.rd_we && (dec_bus.rd_addr != '0);
      lsu_we_d = dec_bus.lsu_we && is_lsu;
      alu_op_d = dec_bus.alu_op;
    end
  end

  // Later updates take precedence when two of them target the same register.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid_i) busy_d[wb_addr_i] = 1'b0;
    if (flush_i && iss_valid && rd_we_q) busy_d[rd_q] = 1'b0;
    if (accept && dec_bus.rd_we && (dec_bus.rd_addr != '0)) busy_d[dec_bus.rd_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    scnt_d = scnt_q;
    if (dec_bus.dec_valid && haz && !flush_i && (scnt_q != '1)) scnt_d = scnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_EMPTY;
      busy_q   <= '0;
      scnt_q   <= '0;
      unit_q   <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      wdata_q  <= '0;
      pc_q     <= '0;
      rd_q     <= '0;
      rd_we_q  <= 1'b0;
      lsu_we_q <= 1'b0;
      alu_op_q <= ALU_ADD;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      scnt_q   <= scnt_d;
      unit_q   <= unit_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      wdata_q  <= wdata_d;
      pc_q     <= pc_d;
      rd_q     <= rd_d;
      rd_we_q  <= rd_we_d;
      lsu_we_q <= lsu_we_d;
      alu_op_q <= alu_op_d;
    end
  end

  assign iss_bus.iss_valid = iss_valid;
  assign iss_bus.iss_unit  = unit_q;
  assign iss_bus.operand_a = opa_q;
  assign iss_bus.operand_b = opb_q;
  assign iss_bus.lsu_wdata = wdata_q;
  assign iss_bus.pc        = pc_q;
  assign iss_bus.rd_addr   = rd_q;
  assign iss_bus.rd_we     = rd_we_q;
  assign iss_bus.lsu_we    = lsu_we_q;
  assign iss_bus.alu_op    = alu_op_q;
  assign stall_cnt_o       = scnt_q;

endmodule

// File: tb/tb_issue_sb.sv
// Bench for issue_sb: a table of independent instructions plus hand sequences for stalls,
// back-pressure, flush, WAW and counter saturation. Issued payloads are checked against a queue.
module tb_issue_sb;
  import issue_sb_pkg::*;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int AW     = 5;
  localparam int SCNT_W = 4;

  typedef struct packed {
    logic [AW-1:0]   rs1, rs2, rd;
    logic            u1, u2, we;
    logic [1:0]      asel;
    logic            bsel;
    logic [1:0]      unit;
    alu_op_e         op;
    logic            lsu_we;
    logic [XLEN-1:0] imm, pc;
  } instr_t;

  typedef struct packed {
    logic [XLEN-1:0] a, b, wd, pc;
    logic [AW-1:0]   rd;
    logic            rd_we, lsu_we;
    logic [1:0]      unit;
    alu_op_e         op;
  } exp_t;

  typedef struct packed {
    instr_t in;
    exp_t   ex;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [XLEN-1:0]   rf_a, rf_b;
  logic              wb_valid;
  logic [AW-1:0]     wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              flush;
  logic [SCNT_W-1:0] stall_cnt;
  logic [XLEN-1:0]   rf [NREGS];

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t q[$];
  exp_t mon_e;
  vec_t vt [8];
  int   w;

  always #5 clk = ~clk;

  issue_sb_dec_if #(.XLEN(XLEN), .AW(AW)) dec ();
  issue_sb_iss_if #(.XLEN(XLEN), .AW(AW)) iss ();

  assign rf_a = rf[dec.rs1_addr];
  assign rf_b = rf[dec.rs2_addr];

  issue_sb #(.XLEN(XLEN), .NREGS(NREGS), .SCNT_W(SCNT_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .dec_bus      (dec.slave),
    .iss_bus      (iss.master),
    .rf_rdata_a_i (rf_a),
    .rf_rdata_b_i (rf_b),
    .wb_valid_i   (wb_valid),
    .wb_addr_i    (wb_addr),
    .wb_data_i    (wb_data),
    .flush_i      (flush),
    .stall_cnt_o  (stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                                input logic [AW-1:0] rd, input logic u1, input logic u2,
                                input logic we, input logic [1:0] asel, input logic bsel,
                                input logic [1:0] unit, input alu_op_e op, input logic lsu_we,
                                input logic [XLEN-1:0] imm, input logic [XLEN-1:0] pc);
    instr_t i;
    i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.u1 = u1; i.u2 = u2; i.we = we;
    i.asel = asel; i.bsel = bsel; i.unit = unit; i.op = op; i.lsu_we = lsu_we;
    i.imm = imm; i.pc = pc;
    return i;
  endfunction

  function automatic exp_t mkexp(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                 input logic [XLEN-1:0] wd, input logic [XLEN-1:0] pc,
                                 input logic [AW-1:0] rd, input logic rd_we, input logic lsu_we,
                                 input logic [1:0] unit, input alu_op_e op);
    exp_t e;
    e.a = a; e.b = b; e.wd = wd; e.pc = pc; e.rd = rd; e.rd_we = rd_we;
    e.lsu_we = lsu_we; e.unit = unit; e.op = op;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input instr_t i);
    dec.rs1_addr = i.rs1;  dec.rs2_addr = i.rs2;  dec.rd_addr  = i.rd;
    dec.rs1_used = i.u1;   dec.rs2_used = i.u2;   dec.rd_we    = i.we;
    dec.op_a_sel = i.asel; dec.op_b_sel = i.bsel; dec.unit     = i.unit;
    dec.alu_op   = i.op;   dec.lsu_we   = i.lsu_we;
    dec.imm      = i.imm;  dec.pc       = i.pc;
  endtask

  // Offer an instruction until accepted; returns the number of stalled cycles.
  task automatic send(input instr_t i, input exp_t e, output int waited);
    bit done;
    done   = 1'b0;
    waited = 0;
    drive(i);
    dec.dec_valid = 1'b1;
    for (int k = 0; k < 32 && !done; k++) begin
      @(negedge clk);
      if (dec.dec_ready) begin
        q.push_back(e);
        done = 1'b1;
      end else begin
        waited++;
        tick();
      end
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    tick();
    dec.dec_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() != 0; k++) tick();
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    drive(mk(2, 3, 5, 1, 1, 1, 0, 0, 0, ALU_SUB, 0, 32'h0, 32'h99));
    dec.dec_valid = 1'b1;
    flush    = 1'b1;
    wb_valid = 1'b1;
    wb_addr  = 5'd1;
    tick();
    @(negedge clk);
    chk("rst_dec_ready", 32'(dec.dec_ready), 32'd0);
    tick();
    dec.dec_valid = 1'b0;
    flush    = 1'b0;
    wb_valid = 1'b0;
    rst_n    = 1'b1;
    chk("rst_valid",  32'(iss.iss_valid), 32'd0);
    chk("rst_opa",    iss.operand_a, 32'd0);
    chk("rst_opb",    iss.operand_b, 32'd0);
    chk("rst_wdata",  iss.lsu_wdata, 32'd0);
    chk("rst_pc",     iss.pc, 32'd0);
    chk("rst_rd",     32'(iss.rd_addr), 32'd0);
    chk("rst_rd_we",  32'(iss.rd_we), 32'd0);
    chk("rst_lsu_we", 32'(iss.lsu_we), 32'd0);
    chk("rst_unit",   32'(iss.iss_unit), 32'd0);
    chk("rst_alu_op", 32'(iss.alu_op), 32'(ALU_ADD));
    chk("rst_stall",  32'(stall_cnt), 32'd0);
    q.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && iss.iss_valid === 1'b1 && iss.iss_ready === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_issue", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("operand_a", iss.operand_a, mon_e.a);
        chk("operand_b", iss.operand_b, mon_e.b);
        chk("lsu_wdata", iss.lsu_wdata, mon_e.wd);
        chk("pc",        iss.pc, mon_e.pc);
        chk("rd_addr",   32'(iss.rd_addr), 32'(mon_e.rd));
        chk("rd_we",     32'(iss.rd_we), 32'(mon_e.rd_we));
        chk("lsu_we",    32'(iss.lsu_we), 32'(mon_e.lsu_we));
        chk("unit",      32'(iss.iss_unit), 32'(mon_e.unit));
        chk("alu_op",    32'(iss.alu_op), 32'(mon_e.op));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREGS; i++) rf[i] = 32'hA000_0000 + i;
    rf[0] = 32'hFFFF_FFFF;
    rf[2] = 32'd5;
    rf[3] = 32'd7;
    rf[5] = 32'd11;
    rf[6] = 32'd13;

    vt[0] = '{mk(2, 3, 0, 1, 1, 1, 0, 0, 0, ALU_ADD, 0, 32'h0, 32'h1000),
              mkexp(32'd5, 32'd7, 32'd0, 32'h1000, 0, 0, 0, 0, ALU_ADD)};
    vt[1] = '{mk(0, 0, 0, 0, 0, 0, 2, 1, 1, ALU_ADD, 0, 32'hFFFF_FFF8, 32'h100),
              mkexp(32'h100, 32'hFFFF_FFF8, 32'd0, 32'h100, 0, 0, 0, 1, ALU_ADD)};
    vt[2] = '{mk(5, 6, 0, 1, 1, 0, 0, 1, 2, ALU_ADD, 1, 32'd4, 32'h1008),
              mkexp(32'd11, 32'd4, 32'd13, 32'h1008, 0, 0, 1, 2, ALU_ADD)};
    vt[3] = '{mk(9, 0, 0, 0, 0, 0, 1, 1, 0, ALU_SUB, 0, 32'h55, 32'h100C),
              mkexp(32'd0, 32'h55, 32'd0, 32'h100C, 0, 0, 0, 0, ALU_SUB)};
    vt[4] = '{mk(8, 0, 0, 1, 1, 0, 3, 0, 0, ALU_XOR, 0, 32'h77, 32'h1010),
              mkexp(32'd0, 32'd0, 32'd0, 32'h1010, 0, 0, 0, 0, ALU_XOR)};
    vt[5] = '{mk(10, 3, 0, 1, 1, 0, 0, 0, 0, ALU_AND, 1, 32'h0, 32'h1014),
              mkexp(32'hA000_000A, 32'd7, 32'd0, 32'h1014, 0, 0, 0, 0, ALU_AND)};
    vt[6] = '{mk(6, 5, 0, 1, 0, 0, 0, 1, 2, ALU_ADD, 0, 32'h10, 32'h1018),
              mkexp(32'd13, 32'h10, 32'd0, 32'h1018, 0, 0, 0, 2, ALU_ADD)};
    vt[7] = '{mk(2, 2, 12, 1, 1, 1, 0, 0, 0, ALU_SLT, 0, 32'h0, 32'h101C),
              mkexp(32'd5, 32'd5, 32'd0, 32'h101C, 12, 1, 0, 0, ALU_SLT)};

    iss.iss_ready = 1'b1;
    wb_valid      = 1'b0;
    wb_addr       = '0;
    wb_data       = '0;
    flush         = 1'b0;
    dec.dec_valid = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ALU_ADD, 0, 32'h0, 32'h0));
    reset_dut();

    // Back-to-back independent ALU ops; x1 and x4 become busy
    send(mk(2, 3, 1, 1, 1, 1, 0, 0, 0, ALU_ADD, 0, 32'h0, 32'h10),
         mkexp(32'd5, 32'd7, 32'd0, 32'h10, 1, 1, 0, 0, ALU_ADD), w);
    chk("b2b_valid1", 32'(iss.iss_valid), 32'd1);
    send(mk(5, 6, 4, 1, 1, 1, 0, 0, 0, ALU_ADD, 0, 32'h0, 32'h14),
         mkexp(32'd11, 32'd13, 32'd0, 32'h14, 4, 1, 0, 0, ALU_ADD), w);
    chk("b2b_valid2", 32'(iss.iss_valid), 32'd1);
    chk("b2b_nostall", 32'(w), 32'd0);
    drive(mk(1, 0, 0, 1, 0, 0, 0, 1, 0, ALU_ADD, 0, 32'h0, 32'h0));
    @(negedge clk);
    chk("busy_x1", 32'(dec.dec_ready), 32'd0);
    drive(mk(4, 0, 0, 1, 0, 0, 0, 1, 0, ALU_ADD, 0, 32'h0, 32'h0));
    #1 chk("busy_x4", 32'(dec.dec_ready), 32'd0);
    drive(mk(2, 0, 0, 1, 0, 0, 0, 1, 0, ALU_ADD, 0, 32'h0, 32'h0));
    #1 chk("free_x2", 32'(dec.dec_ready), 32'd1);
    tick();

    // RAW stall resolved by a same-cycle write-back
    drive(mk(1, 0, 0, 1, 0, 0, 0, 1, 0, ALU_ADD, 0, 32'h0, 32'h20));
    dec.dec_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("raw_stall_rdy", 32'(dec.dec_ready), 32'd0);
      tick();
      chk($sformatf("raw_stall_cnt%0d", k), 32'(stall_cnt), 32'(k));
    end
    wb_valid = 1'b1;
    wb_addr  = 5'd1;
    wb_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("raw_fwd_rdy", 32'(dec.dec_ready), 32'd1);
    q.push_back(mkexp(32'hDEAD_BEEF, 32'd0, 32'd0, 32'h20, 0, 0, 0, 0, ALU_ADD));
    tick();
    dec.dec_valid = 1'b0;
    chk("raw_cnt_hold", 32'(stall_cnt), 32'd3);
    wb_addr = 5'd4;
    wb_data = 32'h0;
    tick();
    wb_valid = 1'b0;
    drain();

    for (int i = 0; i < 8; i++) begin
      send(vt[i].in, vt[i].ex, w);
      chk($sformatf("vec%0d_nostall", i), 32'(w), 32'd0);
    end
    drain();

    // Back-pressure holds the payload and blocks decode
    iss.iss_ready = 1'b0;
    send(mk(2, 3, 0, 1, 1, 0, 0, 0, 0, ALU_ADD, 0, 32'h0, 32'h200),
         mkexp(32'd5, 32'd7, 32'd0, 32'h200, 0, 0, 0, 0, ALU_ADD), w);
    drive(mk(0, 0, 0, 0, 0, 0, 2, 1, 0, ALU_OR, 0, 32'd9, 32'h204));
    dec.dec_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(iss.iss_valid), 32'd1);
      chk("bp_opa",   iss.operand_a, 32'd5);
      chk("bp_pc",    iss.pc, 32'h200);
      chk("bp_rdy",   32'(dec.dec_ready), 32'd0);
      tick();
    end
    iss.iss_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_rdy", 32'(dec.dec_ready), 32'd1);
    q.push_back(mkexp(32'h204, 32'd9, 32'd0, 32'h204, 0, 0, 0, 0, ALU_OR));
    tick();
    dec.dec_valid = 1'b0;
    chk("bp_next_valid", 32'(iss.iss_valid), 32'd1);
    chk("bp_next_pc",    iss.pc, 32'h204);
    chk("bp_cnt",        32'(stall_cnt), 32'd3);
    drain();

    // Flush of a held instruction writing x7, then x7 is readable at once
    iss.iss_ready = 1'b0;
    send(mk(2, 3, 7, 1, 1, 1, 0, 0, 0, ALU_ADD, 0, 32'h0, 32'h300),
         mkexp(32'd5, 32'd7, 32'd0, 32'h300, 7, 1, 0, 0, ALU_ADD), w);
    drive(mk(7, 0, 0, 1, 0, 0, 0, 1, 0, ALU_ADD, 0, 32'h0, 32'h304));
    dec.dec_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_rdy", 32'(dec.dec_ready), 32'd0);
    tick();
    flush = 1'b0;
    void'(q.pop_back());
    chk("flush_valid", 32'(iss.iss_valid), 32'd0);
    iss.iss_ready = 1'b1;
    send(mk(7, 0, 0, 1, 0, 0, 0, 1, 0, ALU_ADD, 0, 32'h0, 32'h304),
         mkexp(32'hA000_0007, 32'd0, 32'd0, 32'h304, 0, 0, 0, 0, ALU_ADD), w);
    chk("flush_nostall", 32'(w), 32'd0);
    chk("flush_cnt", 32'(stall_cnt), 32'd3);
    drain();

    // x0 destinations never stall or mark busy
    send(mk(2, 3, 0, 1, 1, 1, 0, 0, 0, ALU_ADD, 0, 32'h0, 32'h400),
         mkexp(32'd5, 32'd7, 32'd0, 32'h400, 0, 0, 0, 0, ALU_ADD), w);
    send(mk(0, 0, 0, 1, 1, 1, 0, 0, 0, ALU_ADD, 0, 32'h0, 32'h404),
         mkexp(32'd0, 32'd0, 32'd0, 32'h404, 0, 0, 0, 0, ALU_ADD), w);
    chk("x0_nostall", 32'(w), 32'd0);

    // WAW on x3, released by a write-back that coincides with the new claim
    send(mk(2, 0, 3, 1, 0, 1, 0, 1, 0, ALU_ADD, 0, 32'd1, 32'h410),
         mkexp(32'd5, 32'd1, 32'd0, 32'h410, 3, 1, 0, 0, ALU_ADD), w);
    drive(mk(5, 0, 3, 1, 0, 1, 0, 1, 0, ALU_OR, 0, 32'd2, 32'h414));
    dec.dec_valid = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk("waw_rdy", 32'(dec.dec_ready), 32'd0);
      tick();
      chk($sformatf("waw_cnt%0d", k), 32'(stall_cnt), 32'(3 + k));
    end
    wb_valid = 1'b1;
    wb_addr  = 5'd3;
    wb_data  = 32'h33;
    @(negedge clk);
    chk("waw_wb_rdy", 32'(dec.dec_ready), 32'd1);
    q.push_back(mkexp(32'd11, 32'd2, 32'd0, 32'h414, 3, 1, 0, 0, ALU_OR));
    tick();
    dec.dec_valid = 1'b0;
    wb_valid = 1'b0;
    drive(mk(3, 0, 0, 1, 0, 0, 0, 1, 0, ALU_ADD, 0, 32'h0, 32'h0));
    @(negedge clk);
    chk("waw_busy_kept", 32'(dec.dec_ready), 32'd0);
    wb_valid = 1'b1;
    #1 chk("wb_resolves", 32'(dec.dec_ready), 32'd1);
    tick();
    wb_valid = 1'b0;
    drain();

    // Stall counter saturation
    reset_dut();
    send(mk(2, 3, 1, 1, 1, 1, 0, 0, 0, ALU_ADD, 0, 32'h0, 32'h500),
         mkexp(32'd5, 32'd7, 32'd0, 32'h500, 1, 1, 0, 0, ALU_ADD), w);
    drive(mk(1, 0, 0, 1, 0, 0, 0, 1, 0, ALU_ADD, 0, 32'h0, 32'h504));
    dec.dec_valid = 1'b1;
    repeat (14) tick();
    chk("sat_cnt14", 32'(stall_cnt), 32'd14);
    repeat (6) tick();
    chk("sat_cnt20", 32'(stall_cnt), 32'd15);
    dec.dec_valid = 1'b0;
    wb_valid = 1'b1;
    wb_addr  = 5'd1;
    tick();
    wb_valid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
